// File: rtl/resta_pf_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (A - B), one shift per clock.
// Define RESTAPF_RNE_EN to add a round-to-nearest-even stage (RND); otherwise results truncate.
module resta_pf_seq #(
   parameter int ALIGN_CAP = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [7:0]  CAP = ALIGN_CAP[7:0];
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ALIGN,
      S_OP,
      S_NORM,
`ifdef RESTAPF_RNE_EN
      S_RND,
`endif
      S_DONE
   } state_t;

   state_t      state, state_n;
   logic [31:0] op_a, op_a_n, op_b, op_b_n;
   logic        sx, sx_n, sy, sy_n;
   logic [7:0]  ex, ex_n, cnt, cnt_n;
   logic [27:0] mx, mx_n, my, my_n;
   logic [31:0] result_n;
   logic        fin;

   // Datapath layout: [27] carry, [26] hidden, [25:3] mantissa, [2] G, [1] R, [0] S.
   logic        swap;
   logic [7:0]  exp_x, exp_y, diff, ex_inc, ex_dec;
   logic [27:0] sig_a, sig_b, sig_x, sig_y, sum, shr, shl, my_shr;

   assign sig_a  = (op_a[30:23] == 8'h00) ? 28'h0 : {2'b01, op_a[22:0], 3'b000};
   assign sig_b  = (op_b[30:23] == 8'h00) ? 28'h0 : {2'b01, op_b[22:0], 3'b000};
   assign swap   = op_b[30:0] > op_a[30:0];
   assign exp_x  = swap ? op_b[30:23] : op_a[30:23];
   assign exp_y  = swap ? op_a[30:23] : op_b[30:23];
   assign sig_x  = swap ? sig_b : sig_a;
   assign sig_y  = swap ? sig_a : sig_b;
   assign diff   = exp_x - exp_y;
   assign sum    = (sx == sy) ? (mx + my) : (mx - my);
   assign shr    = {1'b0, mx[27:2], mx[1] | mx[0]};
   assign shl    = {mx[26:0], 1'b0};
   assign my_shr = {1'b0, my[27:2], my[1] | my[0]};
   assign ex_inc = ex + 8'd1;
   assign ex_dec = ex - 8'd1;

`ifdef RESTAPF_RNE_EN
   logic        rnd_up;
   logic [24:0] rnd_sum;
   assign rnd_up  = mx[2] & (mx[1] | mx[0] | mx[3]);
   assign rnd_sum = {1'b0, mx[26:3]} + {24'h0, rnd_up};
`endif

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         sx     <= 1'b0;
         sy     <= 1'b0;
         ex     <= '0;
         cnt    <= '0;
         mx     <= '0;
         my     <= '0;
         result <= '0;
      end else begin
         state  <= state_n;
         op_a   <= op_a_n;
         op_b   <= op_b_n;
         sx     <= sx_n;
         sy     <= sy_n;
         ex     <= ex_n;
         cnt    <= cnt_n;
         mx     <= mx_n;
         my     <= my_n;
         result <= result_n;
      end
   end

   always_comb begin
      state_n  = state;
      op_a_n   = op_a;
      op_b_n   = op_b;
      sx_n     = sx;
      sy_n     = sy;
      ex_n     = ex;
      cnt_n    = cnt;
      mx_n     = mx;
      my_n     = my;
      result_n = result;
      fin      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               op_a_n  = A;
               op_b_n  = {~B[31], B[30:0]};
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            if (op_a[30:23] == 8'hFF || op_b[30:23] == 8'hFF) begin
               result_n = QNAN;
               state_n  = S_DONE;
            end else begin
               sx_n = swap ? op_b[31] : op_a[31];
               sy_n = swap ? op_a[31] : op_b[31];
               ex_n = exp_x;
               mx_n = sig_x;
               // Beyond the cap the smaller operand only survives as sticky.
               if (diff > CAP) begin
                  my_n    = {27'h0, |sig_y};
                  cnt_n   = 8'h00;
                  state_n = S_OP;
               end else begin
                  my_n    = sig_y;
                  cnt_n   = diff;
                  state_n = (diff == 8'h00) ? S_OP : S_ALIGN;
               end
            end
         end
         S_ALIGN: begin
            my_n  = my_shr;
            cnt_n = cnt - 8'd1;
            if (cnt == 8'd1) state_n = S_OP;
         end
         S_OP: begin
            if (sum == 28'h0) begin
               result_n = 32'h0;
               state_n  = S_DONE;
            end else begin
               mx_n = sum;
               if (sum[27] || !sum[26]) state_n = S_NORM;
               else fin = 1'b1;
            end
         end
         S_NORM: begin
            if (mx[27]) begin
               if (ex_inc == 8'hFF) begin
                  result_n = {sx, 8'hFF, 23'h0};
                  state_n  = S_DONE;
               end else begin
                  mx_n = shr;
                  ex_n = ex_inc;
                  fin  = 1'b1;
               end
            end else if (ex_dec == 8'h00) begin
               result_n = {sx, 31'h0};
               state_n  = S_DONE;
            end else begin
               mx_n = shl;
               ex_n = ex_dec;
               if (shl[26]) fin = 1'b1;
            end
         end
`ifdef RESTAPF_RNE_EN
         S_RND: begin
            state_n = S_DONE;
            if (rnd_sum[24]) begin
               if (ex_inc == 8'hFF) result_n = {sx, 8'hFF, 23'h0};
               else result_n = {sx, ex_inc, rnd_sum[23:1]};
            end else begin
               result_n = {sx, ex, rnd_sum[22:0]};
            end
         end
`endif
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // A normalised significand is ready: round it or pack it straight away.
      if (fin) begin
`ifdef RESTAPF_RNE_EN
         state_n  = S_RND;
`else
         state_n  = S_DONE;
         result_n = {sx, ex_n, mx_n[25:3]};
`endif
      end
   end

endmodule
